inst_fifo: RTL
==============

INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of two, at least 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset.
REQ-004 SHALL have port flush  input  1  discard all queued entries (redirect or exception).
REQ-005 SHALL have ports push_en1, push_en2  input  1 each  fetch slot valid; push_en2 is ignored unless push_en1=1.
REQ-006 SHALL have ports push_inst1, push_inst2  input  32 each  fetched instruction words.
REQ-007 SHALL have ports push_pc1, push_pc2  input  32 each  PCs of the fetched instructions.
REQ-008 SHALL have port pop_num  input  2  entries consumed by decode this cycle (0, 1 or 2; 3 is treated as 2).
REQ-009 SHALL have ports out_inst1, out_pc1, out_inst2, out_pc2  output  32 each  head and head+1 entries, feeding instr1D/Pc1D and instr2D/Pc2D.
REQ-010 SHALL have ports out_valid1, out_valid2  output  1 each  slot holds a real entry; out_valid2 drives fifo_read_en2D.
REQ-011 SHALL have port full  output  1  fewer than 2 free entries.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-013 SHALL hold entries in a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-014 SHALL drive out_*1 from buffer[head] and out_*2 from buffer[head+1 mod DEPTH] combinationally.
REQ-015 SHALL set out_valid1=(count>=1) and out_valid2=(count>=2); invalid slots output zeros.
REQ-016 SHALL clamp the number of entries popped per cycle to min(pop_num, count).
REQ-017 SHALL advance head by the number of entries popped, on the clock edge.
REQ-018 SHALL write entries on the clock edge when full=0: slot 1 to tail, slot 2 to tail+1, in program order.
REQ-019 SHALL advance tail by the number of entries pushed (0, 1 or 2).
REQ-020 SHALL evaluate full on the current count, so a push is accepted only when at least 2 entries are free, regardless of same-cycle pops.
REQ-021 SHALL drop pushes presented while full=1, and fetch SHALL hold and re-present them.
REQ-022 SHALL apply a simultaneous push and pop in the same cycle, with count_next = count + pushed - popped.
REQ-023 SHALL, on flush=1, set head, tail and count to 0 on the next edge and ignore that cycle's push and pop.
REQ-024 SHALL never let count exceed DEPTH or fall below 0.
REQ-025 SHALL keep push-to-out latency at 1 cycle without bypass: an entry written at edge N is visible after edge N.

Reset
REQ-026 SHALL, on rst=0 at a rising edge, clear head, tail and count to 0.
REQ-027 SHALL hold outputs during reset at out_valid1=0, out_valid2=0, full=0, count=0, and out_inst/out_pc=0.
REQ-028 SHALL give reset priority over flush, push and pop, and SHALL discard any operation in flight when reset is applied.
REQ-029 SHALL leave buffer storage uninitialised, since it is unobservable while count=0.

Configuration
REQ-030 SHALL compile the empty-queue bypass path only when INST_FIFO_BYPASS_EN is defined.
REQ-031 SHALL, with INST_FIFO_BYPASS_EN defined and count=0 and flush=0, drive out_*1/out_*2 combinationally from push slot 1/slot 2, with out_valid1=push_en1 and out_valid2=push_en1&push_en2.
REQ-032 SHALL, in bypass mode, not store bypassed entries that decode pops in the same cycle, and SHALL enqueue only the unpopped remainder.
REQ-033 SHALL, without INST_FIFO_BYPASS_EN, make outputs depend only on registered state, with 1-cycle latency per REQ-025.

Verification
REQ-034 SHALL cover: after reset, push 0x11/0x22 at PCs 0x1000/0x1004 with pop_num=0 -> next cycle out_inst1=0x11, out_pc2=0x1004, both valid, count=2.
REQ-035 SHALL cover: fill to count=15 (DEPTH=16) -> full=1; a push is dropped and count stays 15; pop_num=2 -> count=13 and full=0.
REQ-036 SHALL cover: count=1 with pop_num=2 -> exactly 1 popped, count=0, out_valid1=0 the next cycle.
REQ-037 SHALL cover: push 2 while popping 2 for 20 cycles from count=4 -> count stays 4, pointers wrap, and out_pc1 increments by 8 per cycle.
REQ-038 SHALL cover: flush with count=7 and a simultaneous push -> count=0 and both valids 0 the next cycle.
REQ-039 SHALL cover, with INST_FIFO_BYPASS_EN: empty queue, push 2 with pop_num=1 -> out_inst1 equals push_inst1 the same cycle, and count=1 holding slot 2 the next cycle.

Source files
------------

// File: rtl/inst_fifo_if.sv
// Fetch/decode side bundle of the instruction queue: dual-slot push, pop count,
// two head-of-queue output slots and occupancy status.
interface inst_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          push_en1;
  logic          push_en2;
  logic [31:0]   push_inst1;
  logic [31:0]   push_inst2;
  logic [31:0]   push_pc1;
  logic [31:0]   push_pc2;
  logic [1:0]    pop_num;
  logic [31:0]   out_inst1;
  logic [31:0]   out_pc1;
  logic [31:0]   out_inst2;
  logic [31:0]   out_pc2;
  logic          out_valid1;
  logic          out_valid2;
  logic          full;
  logic [CW-1:0] count;

  modport master (
    output flush, push_en1, push_en2, push_inst1, push_inst2, push_pc1, push_pc2, pop_num,
    input  out_inst1, out_pc1, out_inst2, out_pc2, out_valid1, out_valid2, full, count
  );

  modport slave (
    input  flush, push_en1, push_en2, push_inst1, push_inst2, push_pc1, push_pc2, pop_num,
    output out_inst1, out_pc1, out_inst2, out_pc2, out_valid1, out_valid2, full, count
  );
endinterface

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode (circular buffer, 2 in / 2 out).
// Define INST_FIFO_BYPASS_EN to let an empty queue forward fetch slots straight to decode.
module inst_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  inst_fifo_if.slave  fif
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  ptr_t        head_q, tail_q;
  cnt_t        count_q, count_next;
  logic        full_w;
  logic        bypass;
  logic [1:0]  n_req, n_push, pop_req, avail, n_pop, n_store, head_adv;
  logic [31:0] wr_inst0, wr_pc0;
  ptr_t        head_p1, tail_p1;

  // Full leaves room for a full dual push, judged on current occupancy only.
  assign full_w  = (count_q > cnt_t'(DEPTH - 2));
  assign head_p1 = head_q + ptr_t'(1);
  assign tail_p1 = tail_q + ptr_t'(1);

  always_comb begin
    n_req = 2'd0;
    if (fif.push_en1) n_req = fif.push_en2 ? 2'd2 : 2'd1;
    n_push  = full_w ? 2'd0 : n_req;
    pop_req = (fif.pop_num == 2'd3) ? 2'd2 : fif.pop_num;
    avail   = (count_q >= cnt_t'(2)) ? 2'd2 : count_q[1:0];
    bypass  = 1'b0;
`ifdef INST_FIFO_BYPASS_EN
    bypass = (count_q == '0) && !fif.flush;
    if (bypass) avail = n_push;
`endif
    n_pop    = (pop_req < avail) ? pop_req : avail;
    n_store  = n_push;
    head_adv = n_pop;
    wr_inst0 = fif.push_inst1;
    wr_pc0   = fif.push_pc1;
    // Bypassed entries consumed by decode never enter storage; only the remainder is queued.
    if (bypass) begin
      n_store  = n_push - n_pop;
      head_adv = 2'd0;
      if (n_pop == 2'd1) begin
        wr_inst0 = fif.push_inst2;
        wr_pc0   = fif.push_pc2;
      end
    end
    count_next = count_q + cnt_t'(n_store) - cnt_t'(head_adv);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (fif.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + ptr_t'(head_adv);
      tail_q  <= tail_q + ptr_t'(n_store);
      count_q <= count_next;
    end
  end

  // Storage carries no reset; contents are only observed behind count.
  always_ff @(posedge clk) begin
    if (rst && !fif.flush) begin
      if (n_store != 2'd0) begin
        inst_mem[tail_q] <= wr_inst0;
        pc_mem[tail_q]   <= wr_pc0;
      end
      if (n_store == 2'd2) begin
        inst_mem[tail_p1] <= fif.push_inst2;
        pc_mem[tail_p1]   <= fif.push_pc2;
      end
    end
  end

  always_comb begin
    fif.out_valid1 = 1'b0;
    fif.out_valid2 = 1'b0;
    fif.out_inst1  = '0;
    fif.out_pc1    = '0;
    fif.out_inst2  = '0;
    fif.out_pc2    = '0;
    fif.full       = 1'b0;
    fif.count      = '0;
    if (rst) begin
      fif.full  = full_w;
      fif.count = count_q;
      if (bypass) begin
        fif.out_valid1 = fif.push_en1;
        fif.out_valid2 = fif.push_en1 & fif.push_en2;
        if (fif.out_valid1) begin
          fif.out_inst1 = fif.push_inst1;
          fif.out_pc1   = fif.push_pc1;
        end
        if (fif.out_valid2) begin
          fif.out_inst2 = fif.push_inst2;
          fif.out_pc2   = fif.push_pc2;
        end
      end else begin
        fif.out_valid1 = (count_q >= cnt_t'(1));
        fif.out_valid2 = (count_q >= cnt_t'(2));
        if (fif.out_valid1) begin
          fif.out_inst1 = inst_mem[head_q];
          fif.out_pc1   = pc_mem[head_q];
        end
        if (fif.out_valid2) begin
          fif.out_inst2 = inst_mem[head_p1];
          fif.out_pc2   = pc_mem[head_p1];
        end
      end
    end
  end
endmodule
